// File: rtl/mc_mem_arbiter.sv
// mc_mem_arbiter: shares one synchronous-read memory between the multicycle CPU
// controller and the program loader. Each access takes IDLE -> ACC -> RESP, and the
// requester's ack pulses in the following IDLE cycle. Round-robin applies when both
// request at once, and ldr_lock lets the loader keep the memory for a burst.
// Optional feature macro: ARB_STATS_EN adds saturating cpu_wait_cnt / ldr_grant_cnt.
module mc_mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARB_STATS_EN
  output logic [15:0]       cpu_wait_cnt,
  output logic [15:0]       ldr_grant_cnt,
`endif
  output logic              owner
);

  typedef enum logic [1:0] {StIdle, StAcc, StResp} state_e;

  state_e state_q;
  logic   cur_q;  // owner of the in-flight access: 0 = CPU, 1 = loader
  logic   wr_q;   // in-flight access is a write; mem_we itself drops after ACC

  logic cpu_elig;
  logic ldr_elig;
  logic grant_ldr;
  logic grant_any;

  // A requester whose ack is high this cycle is skipped so a held req cannot re-issue.
  assign cpu_elig  = cpu_req & ~cpu_ack & ~ldr_lock;
  assign ldr_elig  = ldr_req & ~ldr_ack;
  // Loader wins if alone, or if both are eligible and the CPU was the last owner.
  assign grant_ldr = ldr_elig & (~cpu_elig | ~owner);
  assign grant_any = (state_q == StIdle) & (cpu_elig | ldr_elig);

  assign cpu_stall = cpu_req & ~cpu_ack;

  // Arbiter FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cur_q     <= 1'b0;
      wr_q      <= 1'b0;
      owner     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          mem_we <= 1'b0;
          if (cpu_elig || ldr_elig) begin
            state_q <= StAcc;
            cur_q   <= grant_ldr;
            owner   <= grant_ldr;
            if (grant_ldr) begin
              mem_we    <= ldr_we;
              wr_q      <= ldr_we;
              mem_addr  <= ldr_addr;
              mem_wdata <= ldr_wdata;
            end else begin
              mem_we    <= cpu_we;
              wr_q      <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end
        end
        StAcc: begin
          mem_we  <= 1'b0;
          state_q <= StResp;
        end
        StResp: begin
          state_q <= StIdle;
          if (cur_q) begin
            ldr_ack <= 1'b1;
            if (!wr_q) ldr_rdata <= mem_rdata;
          end else begin
            cpu_ack <= 1'b1;
            if (!wr_q) cpu_rdata <= mem_rdata;
          end
        end
        default: begin
          state_q <= StIdle;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Saturating statistics: CPU stall cycles and loader grants.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_wait_cnt  <= 16'h0000;
      ldr_grant_cnt <= 16'h0000;
    end else begin
      if (cpu_stall && (cpu_wait_cnt != 16'hFFFF)) cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
      if (grant_any && grant_ldr && (ldr_grant_cnt != 16'hFFFF)) begin
        ldr_grant_cnt <= ldr_grant_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mc_mem_arbiter.sv
// Scoreboard bench for mc_mem_arbiter. Drivers push expected read data into
// per-requester queues when a request is issued. A negedge monitor pops and compares
// those entries whenever an ack appears. In the random phase the CPU uses addresses
// 0x80-0xFF and the loader uses 0x00-0x7F, so expected data does not depend on the
// order in which the arbiter grants the two requesters.
module tb_mc_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
  logic [7:0]  ldr_addr = '0;
  logic [31:0] ldr_wdata = '0;
  logic [31:0] ldr_rdata;
  logic        ldr_ack;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        owner;
`ifdef ARB_STATS_EN
  logic [15:0] cpu_wait_cnt, ldr_grant_cnt;
`endif

  mc_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef ARB_STATS_EN
    .cpu_wait_cnt(cpu_wait_cnt), .ldr_grant_cnt(ldr_grant_cnt),
`endif
    .owner(owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cycles = 0;
  logic mem_load = 1'b1;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] cpu_q [$];
  logic [31:0] ldr_q [$];
  logic [31:0] cpu_last = '0;
  logic [31:0] ldr_last = '0;

  function automatic logic [31:0] seed(input int i);
    logic [7:0] b;
    b = i[7:0];
    if (i == 16) return 32'hDEADBEEF;
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous-read memory: data appears the cycle after the address is presented.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // Monitor: pops the scoreboard on each ack and checks the exclusivity rules.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_we = 1'b0;
    end else begin
      if (mem_we) we_cycles++;
      if (mem_we && prev_we) chk("mem_we_single_cycle", 1, 0);
      prev_we = mem_we;
      if (cpu_ack && ldr_ack) chk("acks_exclusive", 1, 0);
      if (cpu_ack) begin
        if (cpu_q.size() == 0) chk("cpu_unexpected_ack", 1, 0);
        else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (ldr_ack) begin
        if (ldr_q.size() == 0) chk("ldr_unexpected_ack", 1, 0);
        else chk("ldr_rdata", ldr_rdata, ldr_q.pop_front());
      end
    end
  end

  // Reference model: writes update the model memory and leave rdata unchanged.
  task automatic expect_push(input bit is_ldr, input logic we, input logic [7:0] a,
                             input logic [31:0] d);
    logic [31:0] e;
    if (we) begin
      ref_mem[a] = d;
      e = is_ldr ? ldr_last : cpu_last;
    end else begin
      e = ref_mem[a];
    end
    if (is_ldr) begin
      ldr_last = e;
      ldr_q.push_back(e);
    end else begin
      cpu_last = e;
      cpu_q.push_back(e);
    end
  endtask

  // Each driver is called at posedge+1 and returns at posedge+1 of the ack cycle.
  task automatic cpu_do(input logic we, input logic [7:0] a, input logic [31:0] d,
                        output int lat);
    expect_push(1'b0, we, a, d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 0;
    while (1) begin
      @(posedge clk); #1; lat++;
      if (cpu_ack) break;
      if (lat > 200) begin chk("cpu_ack_timeout", 1, 0); break; end
    end
    cpu_req = 1'b0;
  endtask

  task automatic ldr_do(input logic we, input logic [7:0] a, input logic [31:0] d,
                        output int lat);
    expect_push(1'b1, we, a, d);
    ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d;
    lat = 0;
    while (1) begin
      @(posedge clk); #1; lat++;
      if (ldr_ack) break;
      if (lat > 200) begin chk("ldr_ack_timeout", 1, 0); break; end
    end
    ldr_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cpu_ack"}, cpu_ack, 0);
    chk({tag, "_ldr_ack"}, ldr_ack, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_ldr_rdata"}, ldr_rdata, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int lat, lat2, t0, rel_cyc, cpu_ack_cyc, ldr_cnt, stall_bad, acks, w0;
    int la [2];
    int ca [2];
    bit cpu_done, ldr_done;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    repeat (2) @(posedge clk);
    mem_load = 1'b0;
    check_reset_values("reset");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // CPU-only read of the preloaded word: stall during cycles 0-2, ack in cycle 3.
    expect_push(1'b0, 1'b0, 8'h10, 32'h0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rd_stall_c%0d", c), cpu_stall, (c < 3) ? 1 : 0);
      chk($sformatf("rd_ack_c%0d", c), cpu_ack, (c == 3) ? 1 : 0);
    end
    chk("rd_deadbeef", cpu_rdata, 32'hDEADBEEF);
    cpu_req = 1'b0;
    @(posedge clk); #1;

    // Loader write, then CPU reads the same word back.
    w0 = we_cycles;
    ldr_do(1'b1, 8'h05, 32'h12345678, lat);
    chk("ldr_wr_lat", lat, 3);
    chk("ldr_wr_we_cycles", we_cycles - w0, 1);
    cpu_do(1'b0, 8'h05, 32'h0, lat);
    #1;
    chk("cpu_rd_after_ldr", cpu_rdata, 32'h12345678);
    @(posedge clk); #1;

    // Both held continuously from owner = 0: loader, CPU, loader, CPU.
    chk("rr_owner_start", owner, 0);
    t0 = cyc;
    fork
      for (int k = 0; k < 2; k++) begin
        ldr_do(1'b0, 8'h06 + 8'(k), 32'h0, lat);
        la[k] = cyc - t0;
      end
      for (int k = 0; k < 2; k++) begin
        cpu_do(1'b0, 8'h86 + 8'(k), 32'h0, lat2);
        ca[k] = cyc - t0;
      end
    join
    chk("rr_ldr_ack0", la[0], 3);
    chk("rr_cpu_ack0", ca[0], 6);
    chk("rr_ldr_ack1", la[1], 9);
    chk("rr_cpu_ack1", ca[1], 12);
    @(posedge clk); #1;

    // Lock held for at least 20 cycles while the loader performs 5 writes.
    ldr_lock = 1'b1;
    t0 = cyc;
    ldr_cnt = 0;
    stall_bad = 0;
    rel_cyc = 0;
    cpu_ack_cyc = 0;
`ifdef ARB_STATS_EN
    w0 = int'(cpu_wait_cnt);
    lat2 = int'(ldr_grant_cnt);
`endif
    fork
      begin
        cpu_do(1'b0, 8'hA0, 32'h0, lat);
        cpu_ack_cyc = cyc;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          ldr_do(1'b1, 8'h20 + 8'(k), $urandom, lat);
          ldr_cnt++;
        end
        while (cyc - t0 < 20) begin @(posedge clk); #1; end
`ifdef ARB_STATS_EN
        chk("stats_wait_ge10", (int'(cpu_wait_cnt) - w0) >= 10, 1);
        chk("stats_ldr_grants", int'(ldr_grant_cnt) - lat2, 5);
`endif
        ldr_lock = 1'b0;
        rel_cyc = cyc;
      end
      begin
        @(negedge clk);
        while (ldr_lock) begin
          if (!cpu_stall || cpu_ack) stall_bad++;
          @(negedge clk);
        end
      end
    join
    chk("lock_ldr_acks", ldr_cnt, 5);
    chk("lock_stall_held", stall_bad, 0);
    chk("lock_cpu_after_release", cpu_ack_cyc > rel_cyc, 1);
    chk("lock_cpu_within3", (cpu_ack_cyc - rel_cyc) <= 3, 1);
    @(posedge clk); #1;

    // Reset during the ACC cycle of a CPU write aborts it.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h90; cpu_wdata = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk);
    chk("abort_we_in_acc", mem_we, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_we_drop", mem_we, 0);
    cpu_req = 1'b0;
    cpu_q.delete(); ldr_q.delete();
    cpu_last = '0; ldr_last = '0;
    repeat (2) @(negedge clk);
    check_reset_values("abort");
    reset_n = 1'b1;
    acks = 0;
    repeat (4) begin @(negedge clk); if (cpu_ack) acks++; end
    chk("abort_no_ack", acks, 0);
    check_reset_values("post_abort");
    @(posedge clk); #1;
    cpu_do(1'b0, 8'h90, 32'h0, lat);
    chk("abort_idle_lat", lat, 3);

`ifdef ARB_STATS_EN
    // Saturation: starting from all-ones, further stall cycles keep the counter there.
    ldr_lock = 1'b1;
    fork
      cpu_do(1'b0, 8'h91, 32'h0, lat);
      begin
        force dut.cpu_wait_cnt = 16'hFFFF;
        repeat (2) @(posedge clk);
        release dut.cpu_wait_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("stats_wait_sat", cpu_wait_cnt, 16'hFFFF);
        ldr_lock = 1'b0;
      end
    join
`endif

    // Randomised concurrent traffic with random lock bursts.
    cpu_done = 1'b0;
    ldr_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          cpu_do(1'($urandom), {1'b1, 7'($urandom)}, $urandom, lat);
          chk("rand_cpu_lat_min", lat >= 3, 1);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        cpu_done = 1'b1;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          ldr_do(1'($urandom), {1'b0, 7'($urandom)}, $urandom, lat2);
          chk("rand_ldr_lat_min", lat2 >= 3, 1);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        ldr_done = 1'b1;
      end
      begin
        while (!(cpu_done && ldr_done)) begin
          @(posedge clk); #1;
          if ($urandom_range(0, 7) == 0) ldr_lock = ~ldr_lock;
        end
        ldr_lock = 1'b0;
      end
    join

    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", cpu_q.size() + ldr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_mem_arbiter.md
Name: mc_mem_arbiter

Overview:
- Shares the single synchronous-read instruction/data memory between the multicycle CPU controller (fetch, LDR, STR) and the program loader (boot/debug writes and readback).
- Sits between both requesters and the memory.
- Serialises accesses with a req/ack handshake and round-robin fairness.
- Supports a loader lock for uninterrupted bursts, and stalls the CPU while its access is pending.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, memory data width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data, registered.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- cpu_stall  out  1  cpu_req & ~cpu_ack; freezes the controller state counter.
- ldr_req  in  1  loader access request; held until ldr_ack.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_lock  in  1  while high, the loader owns memory and CPU requests are not granted.
- ldr_rdata  out  DATA_W  loader read data, registered.
- ldr_ack  out  1  one-cycle completion pulse to loader.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after address presented.
- owner  out  1  last granted requester: 0 = CPU, 1 = loader.

Behaviour:
- States: IDLE, ACC, RESP. Reg cur (0 = CPU, 1 = loader) holds the owner of the in-flight access.
- Reset (async, reset_n = 0): state = IDLE, owner = 0, cur = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_ack = 0, ldr_ack = 0, cpu_rdata = 0, ldr_rdata = 0.
  - Reset mid-access aborts it; mem_we drops immediately, no ack issued.
- Eligibility in IDLE:
  - cpu eligible = cpu_req & ~cpu_ack & ~ldr_lock.
  - ldr eligible = ldr_req & ~ldr_ack.
  - A requester whose ack is high this cycle is ignored, so a held req cannot double-issue.
- Arbitration in IDLE:
  - Only one eligible: grant it.
  - Both eligible: grant the one ≠ owner (round-robin).
  - On grant: cur = owner = winner; register the winner's addr/we/wdata onto mem_*; go to ACC.
  - None eligible: stay in IDLE with mem_we = 0.
- ACC (1 cycle):
  - mem_we = registered we; the memory performs the write, or latches the read address.
  - Next state RESP; mem_we cleared on exit.
- RESP (1 cycle): on exit, capture mem_rdata into cur's rdata register (reads only; rdata unchanged on writes), pulse cur's ack for exactly one cycle, return to IDLE.
- Latency: req sampled in cycle n (IDLE) -> ack high in cycle n+3. The earliest next grant is cycle n+3, so the sustained rate is 1 access per 3 cycles.
- Requester inputs are only sampled in IDLE. Changes while in ACC/RESP have no effect on the in-flight access.
- ldr_lock:
  - Rising during a CPU access does not abort it; the CPU access completes.
  - While held, the CPU waits indefinitely and cpu_stall stays high.
  - When released, the CPU is eligible the next IDLE cycle.
- Never two accesses in flight. cpu_ack and ldr_ack are never high together.
- Address width is a pure passthrough; no wrap or range check.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds ports cpu_wait_cnt (out, 16) and ldr_grant_cnt (out, 16), both reset to 0.
  - cpu_wait_cnt increments each cycle cpu_stall = 1.
  - ldr_grant_cnt increments on each loader grant.
  - Both saturate at 16'hFFFF and do not wrap.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- CPU-only read: preload mem[8'h10] = 32'hDEADBEEF, cpu_req = 1, cpu_we = 0, cpu_addr = 8'h10 at cycle 0 -> cpu_ack pulses at cycle 3 with cpu_rdata = 32'hDEADBEEF, cpu_stall high cycles 0–2.
- Loader write then CPU read: ldr writes 32'h12345678 to 8'h05; CPU then reads 8'h05 -> mem_we high exactly 1 cycle, CPU receives 32'h12345678.
- Simultaneous requests held continuously, reset owner = 0 -> grant order loader, CPU, loader, CPU; acks at cycles 3, 6, 9, 12; never both acks high.
- ldr_lock = 1 with cpu_req = 1 for 20 cycles while the loader issues 5 writes -> 5 ldr_acks, 0 cpu_acks; after lock drops, cpu_ack within 3 cycles.
- reset_n low during ACC of a CPU write -> mem_we = 0 immediately, no cpu_ack; after release, state IDLE and all outputs at reset values.
- (ARB_STATS_EN) lock held 10 cycles with cpu_req = 1 -> cpu_wait_cnt ≥ 10; force to 16'hFFFF, keep stalling -> stays 16'hFFFF.
